// File: rtl/rv16_fu_dispatch.sv
// rv16_fu_dispatch: in-order FIFO dispatch to the rs1/rs2 FU demuxes.
// Stalls on busy MUL/DIV and drops illegal opcodes with a sticky flag.
module rv16_fu_dispatch #(
  parameter int DATA    = 4,
  parameter int DEPTH   = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opcode,
  input  logic [DATA-1:0] in_rs1,
  input  logic [DATA-1:0] in_rs2,
  output logic [3:0]      fu_opcode,
  output logic [DATA-1:0] fu_rs1,
  output logic [DATA-1:0] fu_rs2,
  output logic            fu_issue,
  output logic [6:0]      fu_busy,
  output logic            illegal_op,
  input  logic            clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int MW = $clog2(MUL_LAT + 1);
  localparam int DW = $clog2(DIV_LAT + 1);

  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_IDLE = 4'hF;

  typedef struct packed {
    logic [3:0]      op;
    logic [DATA-1:0] rs1;
    logic [DATA-1:0] rs2;
  } op_t;

  op_t            mem [DEPTH];
  op_t            head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [MW-1:0]  mul_cnt;
  logic [DW-1:0]  div_cnt;

  logic head_vld;
  logic is_ill;
  logic can_go;
  logic push;
  logic pop;
  logic issue;
  logic drop;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign head_vld = (count != '0);

  // Unit may take a new op once its counter is on its final cycle.
  always_comb begin
    is_ill = 1'b0;
    can_go = 1'b0;
    unique case (1'b1)
      (head.op >= 4'd7):    is_ill = 1'b1;
      (head.op == OP_MUL):  can_go = (mul_cnt <= MW'(1));
      (head.op == OP_DIV):  can_go = (div_cnt <= DW'(1));
      default:              can_go = 1'b1;
    endcase
  end

  assign issue = head_vld && can_go;
  assign drop  = head_vld && is_ill;
  assign pop   = issue || drop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_opcode, rs1: in_rs1, rs2: in_rs2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt <= '0;
      div_cnt <= '0;
    end else begin
      if (issue && head.op == OP_MUL) mul_cnt <= MW'(MUL_LAT);
      else if (mul_cnt != '0)         mul_cnt <= mul_cnt - 1'b1;
      if (issue && head.op == OP_DIV) div_cnt <= DW'(DIV_LAT);
      else if (div_cnt != '0)         div_cnt <= div_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_issue  <= 1'b0;
      fu_opcode <= OP_IDLE;
      fu_rs1    <= '0;
      fu_rs2    <= '0;
    end else if (issue) begin
      fu_issue  <= 1'b1;
      fu_opcode <= head.op;
      fu_rs1    <= head.rs1;
      fu_rs2    <= head.rs2;
    end else begin
      fu_issue  <= 1'b0;
      fu_opcode <= OP_IDLE;
      fu_rs1    <= '0;
      fu_rs2    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       illegal_op <= 1'b0;
    else if (drop)    illegal_op <= 1'b1;
    else if (clr_err) illegal_op <= 1'b0;
  end

  assign fu_busy = {3'b000, div_cnt != '0, mul_cnt != '0, 2'b00};

endmodule
